// File: rtl/cpu_pkg.sv
// Shared CPU definitions: reset vector, instruction field positions and
// the fetch-unit state encoding.
package cpu_pkg;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;

  typedef enum logic [1:0] {IDLE, REQ, DROP, HOLD} if_state_e;
endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: clear wins over load, otherwise contents hold.
module if_id_register (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] d_instr,
  input  logic [31:0] d_pc_plus4,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc_plus4
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid    <= 1'b0;
      instr    <= '0;
      pc_plus4 <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid    <= 1'b1;
      instr    <= d_instr;
      pc_plus4 <= d_pc_plus4;
    end
  end
endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: drives the imem handshake, keeps a one-entry skid buffer
// for words that return under stall, and resolves jr/jump/branch redirects.
module instruction_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic        jr,
  input  logic [31:0] jr_addr,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic [5:0]  opcode,
  output logic [4:0]  inst_read_reg_addr1,
  output logic [4:0]  inst_read_reg_addr2,
  output logic [4:0]  rd,
  output logic [15:0] inst_imm_field,
  output logic [5:0]  funct
);
  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d, tgt_q, tgt_d;
  logic [31:0] buf_instr_q, buf_instr_d, buf_pc4_q, buf_pc4_d;
  logic        ifid_load, ifid_clear, ifid_from_buf;
  logic        redir, fire;
  logic [31:0] target, pc_plus4;

  assign pc_plus4  = pc_q + 32'd4;
  assign imem_addr = pc_q;
  assign imem_req  = (state_q == REQ) || (state_q == DROP);
  assign fire      = imem_req && imem_ack;
  assign redir     = if_id_valid && !stall && (jr || jump || branch_taken);

  always_comb begin
    target = if_id_pc_plus4 + branch_offset;
    if (jr)        target = jr_addr;
    else if (jump) target = {if_id_pc_plus4[31:28], jump_target, 2'b00};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      tgt_q       <= '0;
      buf_instr_q <= '0;
      buf_pc4_q   <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      tgt_q       <= tgt_d;
      buf_instr_q <= buf_instr_d;
      buf_pc4_q   <= buf_pc4_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    tgt_d         = tgt_q;
    buf_instr_d   = buf_instr_q;
    buf_pc4_d     = buf_pc4_q;
    ifid_load     = 1'b0;
    ifid_clear    = 1'b0;
    ifid_from_buf = 1'b0;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (fire) begin
          pc_d = pc_plus4;
          if (!stall) begin
            ifid_load = 1'b1;
          end else begin
            buf_instr_d = imem_rdata;
            buf_pc4_d   = pc_plus4;
            state_d     = HOLD;
          end
        end
      end
      DROP: begin
        if (fire) begin
          pc_d    = tgt_q;
          state_d = REQ;
        end
      end
      HOLD: begin
        if (!stall) begin
          ifid_load     = 1'b1;
          ifid_from_buf = 1'b1;
          state_d       = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
    // A redirect overrides the sequential path; an outstanding fetch must
    // still be drained, so without ack the target is parked for DROP.
    if (redir) begin
      ifid_load   = 1'b0;
      ifid_clear  = 1'b1;
      buf_instr_d = '0;
      buf_pc4_d   = '0;
      if (imem_req && !imem_ack) begin
        tgt_d   = target;
        pc_d    = pc_q;
        state_d = DROP;
      end else begin
        pc_d    = target;
        state_d = REQ;
      end
    end
  end

  if_id_register u_if_id (
    .clk        (clk),
    .rst        (reset),
    .load       (ifid_load),
    .clear      (ifid_clear),
    .d_instr    (ifid_from_buf ? buf_instr_q : imem_rdata),
    .d_pc_plus4 (ifid_from_buf ? buf_pc4_q : pc_plus4),
    .valid      (if_id_valid),
    .instr      (if_id_instr),
    .pc_plus4   (if_id_pc_plus4)
  );

  assign opcode              = if_id_instr[OPCODE_MSB:OPCODE_LSB];
  assign inst_read_reg_addr1 = if_id_instr[RS_MSB:RS_LSB];
  assign inst_read_reg_addr2 = if_id_instr[RT_MSB:RT_LSB];
  assign rd                  = if_id_instr[RD_MSB:RD_LSB];
  assign inst_imm_field      = if_id_instr[IMM_MSB:IMM_LSB];
  assign funct               = if_id_instr[FUNCT_MSB:FUNCT_LSB];
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed and random bench for instruction_fetch_unit against a
// transaction-level model (pending target, skid queue, IF/ID contents).
module tb_instruction_fetch_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        stall, branch_taken, jump, jr;
  logic [31:0] branch_offset, jr_addr;
  logic [25:0] jump_target;
  logic        if_id_valid;
  logic [31:0] if_id_instr, if_id_pc_plus4;
  logic [5:0]  opcode, funct;
  logic [4:0]  inst_read_reg_addr1, inst_read_reg_addr2, rd;
  logic [15:0] inst_imm_field;

  int total = 0;
  int bad   = 0;

  // reference model state
  bit          m_started, m_drop, m_v;
  logic [31:0] m_pc, m_dtgt, m_instr, m_pc4;
  logic [63:0] m_buf[$];

  always #5 clk = ~clk;

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump(jump), .jump_target(jump_target), .jr(jr), .jr_addr(jr_addr),
    .if_id_valid(if_id_valid), .if_id_instr(if_id_instr), .if_id_pc_plus4(if_id_pc_plus4),
    .opcode(opcode), .inst_read_reg_addr1(inst_read_reg_addr1),
    .inst_read_reg_addr2(inst_read_reg_addr2), .rd(rd),
    .inst_imm_field(inst_imm_field), .funct(funct)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_started = 0; m_drop = 0; m_v = 0;
    m_pc = 32'h0; m_dtgt = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
    m_buf.delete();
  endtask

  task automatic check_all();
    logic [31:0] ei;
    ei = m_instr;
    chk("imem_req", {31'd0, imem_req}, {31'd0, m_started && m_buf.size() == 0});
    chk("imem_addr", imem_addr, m_pc);
    chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_v});
    chk("if_id_instr", if_id_instr, m_instr);
    chk("if_id_pc_plus4", if_id_pc_plus4, m_pc4);
    chk("opcode", {26'd0, opcode}, {26'd0, ei[31:26]});
    chk("rs", {27'd0, inst_read_reg_addr1}, {27'd0, ei[25:21]});
    chk("rt", {27'd0, inst_read_reg_addr2}, {27'd0, ei[20:16]});
    chk("rd", {27'd0, rd}, {27'd0, ei[15:11]});
    chk("imm", {16'd0, inst_imm_field}, {16'd0, ei[15:0]});
    chk("funct", {26'd0, funct}, {26'd0, ei[5:0]});
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic m_edge();
    bit req, fire, redir;
    logic [31:0] tgt;
    req   = m_started && m_buf.size() == 0;
    fire  = req && imem_ack;
    redir = m_v && !stall && (jr || jump || branch_taken);
    if (jr)        tgt = jr_addr;
    else if (jump) tgt = {m_pc4[31:28], jump_target, 2'b00};
    else           tgt = m_pc4 + branch_offset;
    if (redir) begin
      m_v = 0;
      m_buf.delete();
      if (req && !fire) begin m_drop = 1; m_dtgt = tgt; end
      else begin m_pc = tgt; m_drop = 0; end
      m_started = 1;
    end else if (!m_started) begin
      m_started = 1;
    end else if (m_buf.size() != 0) begin
      if (!stall) begin {m_instr, m_pc4} = m_buf.pop_front(); m_v = 1; end
    end else if (fire) begin
      if (m_drop) begin
        m_pc = m_dtgt; m_drop = 0;
      end else if (!stall) begin
        m_v = 1; m_instr = imem_rdata; m_pc4 = m_pc + 32'd4; m_pc = m_pc + 32'd4;
      end else begin
        m_buf.push_back({imem_rdata, m_pc + 32'd4}); m_pc = m_pc + 32'd4;
      end
    end
  endtask

  // Called at a falling edge with inputs applied: check, clock, update model.
  task automatic cyc();
    check_all();
    @(posedge clk);
    m_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    m_reset();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_instr", if_id_instr, 32'h0);
    chk("rst_pc4", if_id_pc_plus4, 32'h0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; imem_ack = 0; imem_rdata = 0; stall = 0;
    branch_taken = 0; branch_offset = 0; jump = 0; jump_target = 0; jr = 0; jr_addr = 0;
    @(negedge clk);
    do_reset();

    // sequential fetch with ack every cycle; ack right after release ignored
    imem_ack = 1; imem_rdata = $urandom;
    chk("idle_req", {31'd0, imem_req}, 32'd0);
    cyc();
    chk("first_addr", imem_addr, 32'h0);
    imem_rdata = $urandom; cyc();
    chk("first_valid", {31'd0, if_id_valid}, 32'd1);
    chk("pc4_a", if_id_pc_plus4, 32'd4);
    chk("addr_4", imem_addr, 32'd4);
    imem_rdata = $urandom; cyc();
    chk("addr_8", imem_addr, 32'd8);
    imem_rdata = $urandom; cyc();
    chk("addr_12", imem_addr, 32'd12);
    imem_rdata = 32'h012A4020; cyc();
    chk("pc4_16", if_id_pc_plus4, 32'd16);
    chk("f_rs", {27'd0, inst_read_reg_addr1}, 32'd9);
    chk("f_rt", {27'd0, inst_read_reg_addr2}, 32'd10);
    chk("f_rd", {27'd0, rd}, 32'd8);
    chk("f_funct", {26'd0, funct}, 32'h20);
    chk("f_opcode", {26'd0, opcode}, 32'd0);

    // slow memory: request and address held until ack
    imem_ack = 0;
    for (int i = 0; i < 3; i++) begin
      chk("slow_addr", imem_addr, 32'h10);
      chk("slow_instr", if_id_instr, 32'h012A4020);
      cyc();
    end
    imem_ack = 1; imem_rdata = 32'hAAAA_0000; stall = 1;
    chk("slow_addr_ack", imem_addr, 32'h10);
    cyc();

    // word returned under stall sits in the skid buffer
    for (int i = 0; i < 4; i++) begin
      imem_rdata = $urandom;
      chk("hold_req", {31'd0, imem_req}, 32'd0);
      chk("hold_instr", if_id_instr, 32'h012A4020);
      cyc();
    end
    stall = 0; cyc();
    chk("unhold_instr", if_id_instr, 32'hAAAA_0000);
    chk("unhold_pc4", if_id_pc_plus4, 32'h14);
    for (int i = 0; i < 3; i++) begin imem_rdata = $urandom; cyc(); end

    // branch with fetch outstanding -> DROP
    chk("br_pc4", if_id_pc_plus4, 32'h20);
    imem_ack = 0; branch_taken = 1; branch_offset = 32'hFFFF_FFF0; cyc();
    branch_taken = 0;
    chk("drop_valid", {31'd0, if_id_valid}, 32'd0);
    chk("drop_addr", imem_addr, 32'h20);
    imem_ack = 1; imem_rdata = 32'hDEAD_BEEF; cyc();
    chk("br_target", imem_addr, 32'h10);
    imem_rdata = $urandom; cyc();

    // jr wins over jump
    jr = 1; jump = 1; jr_addr = 32'h400; jump_target = 26'h3; imem_ack = 0; cyc();
    jr = 0; jump = 0; imem_ack = 1; cyc();
    chk("jr_target", imem_addr, 32'h400);
    imem_rdata = $urandom; cyc();
    jr = 1; jr_addr = 32'hFFFF_FFFC; cyc();
    jr = 0;
    chk("top_addr", imem_addr, 32'hFFFF_FFFC);
    imem_rdata = $urandom; cyc();
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_pc4", if_id_pc_plus4, 32'h0);

    // reset with a fetch in flight
    imem_ack = 0; cyc();
    imem_ack = 1;
    do_reset();

    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      imem_ack      = ($urandom_range(0, 2) != 0);
      imem_rdata    = $urandom;
      stall         = ($urandom_range(0, 3) == 0);
      branch_taken  = ($urandom_range(0, 7) == 0);
      jump          = ($urandom_range(0, 9) == 0);
      jr            = ($urandom_range(0, 11) == 0);
      branch_offset = ($urandom_range(0, 1) == 0) ? ($urandom & 32'h0000_00FC) : ($urandom & 32'hFFFF_FFFC);
      jump_target   = 26'($urandom);
      jr_addr       = $urandom & 32'hFFFF_FFFC;
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
